alu_seq: RTL and testbench
==========================

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 WIDTH, 16, operand/result width in bits; legal values 8, 16, 32, 64.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand/opcode presented.
REQ-005 in_ready  output  1  block can accept a command.
REQ-006 a  input  WIDTH  first operand.
REQ-007 b  input  WIDTH  second operand.
REQ-008 codop  input  4  operation select.
REQ-009 out_valid  output  1  result and flags valid.
REQ-010 out_ready  input  1  consumer accepts result.
REQ-011 out  output  WIDTH  registered result.
REQ-012 neg, zero, overflow  output  1 each  registered flags for the current result.

Function
REQ-013 Command accepted on a rising edge with in_valid=1 and in_ready=1; a, b and codop are captured at that edge.
REQ-014 in_ready SHALL be 1 only in IDLE with rst_n=1; commands presented otherwise are ignored, not queued.
REQ-015 States: IDLE, BUSY, DONE. IDLE->DONE on accepting a single-cycle op. IDLE->BUSY on accepting MUL (REQ-020). BUSY->DONE after WIDTH iterations. DONE->IDLE on an edge with out_ready=1.
REQ-016 out_valid SHALL be 1 exactly in DONE; out and the flags are held stable while out_valid=1 and out_ready=0.
REQ-017 Single-cycle ops: out_valid rises on the edge after acceptance (latency 1). A new command is accepted no earlier than the edge after the DONE->IDLE handshake.
REQ-018 Opcodes: 0 ADD a+b; 1 SUB b-a; 2 SLT (a>b unsigned ? 1 : 0); 3 AND; 4 OR; 5 XOR; 6 SHL b<<a[clog2(WIDTH)-1:0]; 7 SHR logical b>>a[clog2(WIDTH)-1:0]; 8 MUL; 9-15 result 0.
REQ-019 All arithmetic is unsigned modulo 2^WIDTH.
REQ-020 MUL is iterative shift-add, one multiplier bit per cycle, WIDTH cycles in BUSY; out = low WIDTH bits of a*b; out_valid rises WIDTH+1 edges after acceptance.
REQ-021 zero = (out==0); neg = out[WIDTH-1].
REQ-022 overflow: ADD = carry out of bit WIDTH-1; SUB = borrow (a>b); MUL = upper WIDTH product bits nonzero; all other ops 0.
REQ-023 out_valid and out_ready both 1 in DONE with in_valid=1: the result is consumed and the new command is not accepted on that edge.

Reset
REQ-024 rst_n=0 immediately forces state IDLE, out=0, neg=0, zero=0, overflow=0, out_valid=0, with no clock edge required.
REQ-025 Reset asserted in BUSY or DONE discards the operation; no result is produced after release.
REQ-026 First acceptance is possible on the first rising edge with rst_n=1 and in_valid=1.

Configuration
REQ-027 Macro ALU_SEQ_MUL_EN: when defined, MUL is implemented per REQ-020 and REQ-022.
REQ-028 Without ALU_SEQ_MUL_EN, codop 8 behaves as an undefined opcode: single-cycle, out=0, zero=1, overflow=0, and no BUSY state or multiplier datapath is synthesised.

Verification (WIDTH=16)
REQ-029 ADD a=0xFFFF b=0x0001 -> next edge out_valid=1, out=0x0000, zero=1, overflow=1, neg=0.
REQ-030 SUB a=0x0005 b=0x0003 -> out=0xFFFE, neg=1, overflow=1, zero=0; SLT with the same operands -> out=0x0001.
REQ-031 SHL a=0x0004 b=0x0003 -> out=0x0030; SHR a=0x0014 b=0x8000 (shift 4) -> out=0x0800.
REQ-032 MUL with ALU_SEQ_MUL_EN, a=0x0100 b=0x0100 -> in_ready=0 for 16 cycles, out_valid at edge 17, out=0x0000, zero=1, overflow=1; a=0x0003 b=0x0007 -> out=0x0015, overflow=0; without the macro -> out_valid at edge 1, out=0, overflow=0.
REQ-033 Backpressure: out_ready=0 for 3 cycles after ADD 0x0002+0x0003 -> out=0x0005 stable, out_valid=1, in_ready=0 throughout; out_ready=1 -> IDLE next edge.
REQ-034 rst_n low 5 cycles into MUL -> out_valid=0 and out=0 immediately; after release in_ready=1 and no stale result appears.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready command port and a registered, held result.
// Define ALU_SEQ_MUL_EN to build the iterative shift-add multiplier (codop 8).

// state | meaning
// IDLE  | waiting for a command; in_ready=1
// BUSY  | shift-add multiply in progress (ALU_SEQ_MUL_EN only)
// DONE  | out/flags valid, held until out_ready
module alu_seq #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       codop,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             neg,
    output logic             zero,
    output logic             overflow
);

    localparam int SHW = $clog2(WIDTH);
    localparam int CW  = SHW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd1
`ifdef ALU_SEQ_MUL_EN
        ,
        BUSY = 2'd2
`endif
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] res_c;
    logic             ovf_c;
    logic [WIDTH:0]   sum_c;
    logic             accept;

`ifdef ALU_SEQ_MUL_EN
    localparam logic [CW-1:0] ITER = CW'(WIDTH);
    logic [2*WIDTH-1:0] mcand;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      cnt;
`endif

    assign in_ready = rst_n && (state == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        sum_c = {1'b0, a} + {1'b0, b};
        res_c = '0;
        ovf_c = 1'b0;
        case (codop)
            4'd0: begin
                res_c = sum_c[WIDTH-1:0];
                ovf_c = sum_c[WIDTH];
            end
            4'd1: begin
                res_c = b - a;
                ovf_c = (a > b);
            end
            4'd2: res_c = {{(WIDTH-1){1'b0}}, (a > b)};
            4'd3: res_c = a & b;
            4'd4: res_c = a | b;
            4'd5: res_c = a ^ b;
            4'd6: res_c = b << a[SHW-1:0];
            4'd7: res_c = b >> a[SHW-1:0];
            default: begin
                res_c = '0;
                ovf_c = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out       <= '0;
            neg       <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            mcand     <= '0;
            acc       <= '0;
            mplier    <= '0;
            cnt       <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef ALU_SEQ_MUL_EN
                        if (codop == 4'd8) begin
                            state  <= BUSY;
                            mcand  <= {{WIDTH{1'b0}}, a};
                            mplier <= b;
                            acc    <= '0;
                            cnt    <= ITER;
                        end else
`endif
                        begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out       <= res_c;
                            neg       <= res_c[WIDTH-1];
                            zero      <= (res_c == '0);
                            overflow  <= ovf_c;
                        end
                    end
                end
`ifdef ALU_SEQ_MUL_EN
                // One multiplier bit per cycle; the terminal-count cycle publishes the product.
                BUSY: begin
                    if (cnt != '0) begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        out       <= acc[WIDTH-1:0];
                        neg       <= acc[WIDTH-1];
                        zero      <= (acc[WIDTH-1:0] == '0);
                        overflow  <= |acc[2*WIDTH-1:WIDTH];
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed + random bench for alu_seq (WIDTH=16) with a result scoreboard queue.
// Expectations follow ALU_SEQ_MUL_EN when it is defined for the build.
module tb_alu_seq;

`ifdef ALU_SEQ_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a, b;
    logic [3:0]  codop;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        neg, zero, overflow;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [15:0] out;
        logic        neg;
        logic        zero;
        logic        ovf;
        int          lat;
    } exp_t;

    exp_t sb[$];

    alu_seq #(.WIDTH(16)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .codop    (codop),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out      (out),
        .neg      (neg),
        .zero     (zero),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [15:0] x, input logic [15:0] y);
        exp_t        m;
        logic [16:0] s;
        logic [31:0] p;
        m.out = 16'h0;
        m.ovf = 1'b0;
        m.lat = 1;
        case (op)
            4'd0: begin s = {1'b0, x} + {1'b0, y}; m.out = s[15:0]; m.ovf = s[16]; end
            4'd1: begin m.out = y - x; m.ovf = (x > y); end
            4'd2: m.out = (x > y) ? 16'd1 : 16'd0;
            4'd3: m.out = x & y;
            4'd4: m.out = x | y;
            4'd5: m.out = x ^ y;
            4'd6: m.out = y << x[3:0];
            4'd7: m.out = y >> x[3:0];
            4'd8: if (MUL_EN) begin
                p = {16'h0, x} * {16'h0, y};
                m.out = p[15:0];
                m.ovf = |p[31:16];
                m.lat = 17;
            end
            default: m.out = 16'h0;
        endcase
        m.neg  = m.out[15];
        m.zero = (m.out == 16'h0);
        return m;
    endfunction

    // Issue one command, wait (bounded) for its result, compare, hold for 'hold' cycles, then consume.
    task automatic run_cmd(input string tag, input logic [3:0] op, input logic [15:0] x,
                           input logic [15:0] y, input int hold);
        exp_t e;
        int   lat;
        bit   busy_ok;
        @(negedge clk);
        chk({tag, " in_ready"}, in_ready, 1);
        a = x; b = y; codop = op; in_valid = 1'b1;
        sb.push_back(model(op, x, y));
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (!out_valid && lat < 40) begin
            if (in_ready) busy_ok = 1'b0;
            in_valid = 1'b1; codop = 4'd0;
            a = 16'($urandom); b = 16'($urandom);
            @(negedge clk);
            lat++;
        end
        in_valid = 1'b0;
        chk({tag, " busy_in_ready0"}, busy_ok, 1);
        if (sb.size() == 0) begin
            chk({tag, " scoreboard"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, " latency"}, lat, e.lat);
        chk({tag, " out"}, out, e.out);
        chk({tag, " neg"}, neg, e.neg);
        chk({tag, " zero"}, zero, e.zero);
        chk({tag, " overflow"}, overflow, e.ovf);
        chk({tag, " in_ready_done"}, in_ready, 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, " hold out"}, out, e.out);
            chk({tag, " hold valid"}, out_valid, 1);
            chk({tag, " hold in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, " consumed"}, out_valid, 0);
        chk({tag, " idle"}, in_ready, 1);
    endtask

    initial begin
        exp_t e;
        int   stale;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; codop = '0;
        #3;
        chk("rst out_valid", out_valid, 0);
        chk("rst out", out, 0);
        chk("rst flags", {neg, zero, overflow}, 3'b000);
        chk("rst in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel in_ready", in_ready, 1);

        run_cmd("add_ovf", 4'd0, 16'hFFFF, 16'h0001, 0);
        run_cmd("sub",     4'd1, 16'h0005, 16'h0003, 0);
        run_cmd("slt1",    4'd2, 16'h0005, 16'h0003, 0);
        run_cmd("slt0",    4'd2, 16'h0003, 16'h0005, 0);
        run_cmd("and",     4'd3, 16'hF0F0, 16'h3C3C, 0);
        run_cmd("or",      4'd4, 16'hF000, 16'h000F, 0);
        run_cmd("xor",     4'd5, 16'hFFFF, 16'h8001, 0);
        run_cmd("shl",     4'd6, 16'h0004, 16'h0003, 0);
        run_cmd("shr",     4'd7, 16'h0014, 16'h8000, 0);
        run_cmd("mul_ovf", 4'd8, 16'h0100, 16'h0100, 0);
        run_cmd("mul",     4'd8, 16'h0003, 16'h0007, 0);
        run_cmd("undef",   4'd12, 16'h1234, 16'h5678, 0);
        run_cmd("bp_add",  4'd0, 16'h0002, 16'h0003, 3);

        // Handshake edge with a new command pending: consume only, accept on the following edge.
        @(negedge clk);
        a = 16'h00FF; b = 16'h0F0F; codop = 4'd3; in_valid = 1'b1;
        @(negedge clk);
        chk("hs first valid", out_valid, 1);
        chk("hs first out", out, 16'h000F);
        a = 16'hF0F0; b = 16'h0FF0; codop = 4'd5; out_ready = 1'b1;
        e = model(4'd5, 16'hF0F0, 16'h0FF0);
        @(negedge clk);
        out_ready = 1'b0;
        chk("hs consumed", out_valid, 0);
        chk("hs not accepted", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("hs second valid", out_valid, 1);
        chk("hs second out", out, e.out);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;

        for (int i = 0; i < 12; i++)
            run_cmd($sformatf("rnd%0d", i), 4'($urandom_range(0, 15)),
                    16'($urandom), 16'($urandom), 0);

        // Reset in the middle of an operation discards it (BUSY with the multiplier, else DONE).
        run_cmd("pre_rst", 4'd0, 16'h0005, 16'h0005, 0);
        @(negedge clk);
        a = 16'h0003; b = 16'h0007; codop = MUL_EN ? 4'd8 : 4'd0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", out_valid, 0);
        chk("midrst out", out, 0);
        chk("midrst in_ready", in_ready, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("postrst in_ready", in_ready, 1);
        stale = 0;
        repeat (25) begin
            @(negedge clk);
            if (out_valid) stale++;
        end
        chk("postrst no stale", stale, 0);
        run_cmd("postrst_add", 4'd0, 16'h1000, 16'h0234, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
